// File: rtl/ysyx_22040386_mem_responder.sv
// Word-addressed 64-bit RAM answering one valid/ready request at a time after a fixed latency.
// Optional build macro MR_RAND_STALL_EN gates req_ready with a 16-bit LFSR for back-pressure testing.
module ysyx_22040386_mem_responder #(
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          DEPTH     = 4096,
   parameter int          LATENCY   = 1
) (
   input  logic        i_MR_clk,
   input  logic        i_MR_rst,
   input  logic        i_MR_req_valid,
   output logic        o_MR_req_ready,
   input  logic        i_MR_req_wen,
   input  logic [63:0] i_MR_req_addr,
   input  logic [63:0] i_MR_req_wdata,
   input  logic [7:0]  i_MR_req_wmask,
   output logic        o_MR_rsp_valid,
   input  logic        i_MR_rsp_ready,
   output logic [63:0] o_MR_rsp_rdata,
   output logic        o_MR_rsp_err
);

   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
   localparam logic [31:0] CNT_LOAD = (LATENCY >= 2) ? 32'(LATENCY - 2) : 32'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] cnt;
   logic        lat_wen;
   logic [63:0] lat_addr;
   logic [63:0] lat_wdata;
   logic [7:0]  lat_wmask;

   logic        accept;
   logic        enter_resp;
   logic        gate_nxt;
   logic        acc_wen;
   logic [63:0] acc_addr;
   logic [63:0] acc_wdata;
   logic [7:0]  acc_wmask;
   logic [63:0] offset;
   logic        in_range;
   logic [IDX_W-1:0] idx;

   logic [63:0] mem [DEPTH];

`ifdef MR_RAND_STALL_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic        GATE_RST  = LFSR_SEED[0];

   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;

   // Fibonacci LFSR with taps 16,14,13,11, shifting right.
   assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign gate_nxt = lfsr_nxt[0];

   always_ff @(posedge i_MR_clk) begin
      if (i_MR_rst) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_nxt;
      end
   end
`else
   localparam logic GATE_RST = 1'b1;

   assign gate_nxt = 1'b1;
`endif

   assign accept = i_MR_req_valid & o_MR_req_ready;

   // With LATENCY==1 the access happens on the accept edge, before the latches are loaded.
   assign acc_wen   = (state == S_IDLE) ? i_MR_req_wen   : lat_wen;
   assign acc_addr  = (state == S_IDLE) ? i_MR_req_addr  : lat_addr;
   assign acc_wdata = (state == S_IDLE) ? i_MR_req_wdata : lat_wdata;
   assign acc_wmask = (state == S_IDLE) ? i_MR_req_wmask : lat_wmask;

   // Addresses below BASE_ADDR wrap to huge offsets and fail the same compare.
   assign offset   = acc_addr - BASE_ADDR;
   assign in_range = (offset < SPAN);
   assign idx      = offset[IDX_W+2:3];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt == 32'd0) state_nxt = S_RESP;
         S_RESP:  if (i_MR_rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign enter_resp = (state != S_RESP) && (state_nxt == S_RESP);

   always_ff @(posedge i_MR_clk) begin
      if (i_MR_rst) begin
         state          <= S_IDLE;
         cnt            <= 32'd0;
         o_MR_req_ready <= GATE_RST;
         o_MR_rsp_valid <= 1'b0;
         o_MR_rsp_rdata <= 64'd0;
         o_MR_rsp_err   <= 1'b0;
         lat_wen        <= 1'b0;
         lat_addr       <= 64'd0;
         lat_wdata      <= 64'd0;
         lat_wmask      <= 8'd0;
      end else begin
         state          <= state_nxt;
         o_MR_req_ready <= (state_nxt == S_IDLE) & gate_nxt;

         if (accept) begin
            lat_wen   <= i_MR_req_wen;
            lat_addr  <= i_MR_req_addr;
            lat_wdata <= i_MR_req_wdata;
            lat_wmask <= i_MR_req_wmask;
            cnt       <= CNT_LOAD;
         end else if ((state == S_WAIT) && (cnt != 32'd0)) begin
            cnt <= cnt - 32'd1;
         end

         if (enter_resp) begin
            o_MR_rsp_valid <= 1'b1;
            o_MR_rsp_err   <= ~in_range;
            o_MR_rsp_rdata <= (in_range && !acc_wen) ? mem[idx] : 64'd0;
         end else if ((state == S_RESP) && i_MR_rsp_ready) begin
            o_MR_rsp_valid <= 1'b0;
         end
      end
   end

   // RAM is never reset; a write only lands on a clean transition into RESP.
   always_ff @(posedge i_MR_clk) begin
      if (!i_MR_rst && enter_resp && in_range && acc_wen) begin
         for (int b = 0; b < 8; b++) begin
            if (acc_wmask[b]) begin
               mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040386_mem_responder.sv
// Scoreboard bench: a LATENCY=1 and a LATENCY=4 responder checked against a flat-array memory model.
`timescale 1ns/1ps
module tb_ysyx_22040386_mem_responder;

   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          DEPTH = 256;
   localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_wen   [2];
   logic [63:0] req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [7:0]  req_wmask [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [63:0] rsp_rdata [2];
   logic        rsp_err   [2];

   ysyx_22040386_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
      .i_MR_clk(clk), .i_MR_rst(rst),
      .i_MR_req_valid(req_valid[0]), .o_MR_req_ready(req_ready[0]),
      .i_MR_req_wen(req_wen[0]), .i_MR_req_addr(req_addr[0]),
      .i_MR_req_wdata(req_wdata[0]), .i_MR_req_wmask(req_wmask[0]),
      .o_MR_rsp_valid(rsp_valid[0]), .i_MR_rsp_ready(rsp_ready[0]),
      .o_MR_rsp_rdata(rsp_rdata[0]), .o_MR_rsp_err(rsp_err[0])
   );

   ysyx_22040386_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(4)) u_lat4 (
      .i_MR_clk(clk), .i_MR_rst(rst),
      .i_MR_req_valid(req_valid[1]), .o_MR_req_ready(req_ready[1]),
      .i_MR_req_wen(req_wen[1]), .i_MR_req_addr(req_addr[1]),
      .i_MR_req_wdata(req_wdata[1]), .i_MR_req_wmask(req_wmask[1]),
      .o_MR_rsp_valid(rsp_valid[1]), .i_MR_rsp_ready(rsp_ready[1]),
      .o_MR_rsp_rdata(rsp_rdata[1]), .o_MR_rsp_err(rsp_err[1])
   );

   typedef struct {
      int          inst;
      logic [63:0] rdata;
      logic        err;
      int          acc_cyc;
      int          hold;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] ref_mem [2][DEPTH];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Requester side of the response channel: holds rsp_ready low for the
   // requested number of cycles, checks stability, then pops and compares.
   bit          seen      [2];
   int          hold_left [2];
   logic [63:0] cap_rdata [2];
   logic        cap_err   [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rsp_valid[k] !== 1'b1) begin
            rsp_ready[k] = 1'b0;
            seen[k] = 1'b0;
         end else if (exp_q.size() == 0 || exp_q[0].inst != k) begin
            check("unexpected_rsp_valid", 64'(rsp_valid[k]), 64'd0);
            rsp_ready[k] = 1'b1;
            seen[k] = 1'b0;
         end else begin
            if (!seen[k]) begin
               seen[k] = 1'b1;
               check("rsp_latency_cycle", 64'(cyc), 64'(exp_q[0].acc_cyc + lat_of(k)));
               cap_rdata[k] = rsp_rdata[k];
               cap_err[k]   = rsp_err[k];
               hold_left[k] = exp_q[0].hold;
            end else begin
               check("rdata_stable", rsp_rdata[k], cap_rdata[k]);
               check("err_stable", 64'(rsp_err[k]), 64'(cap_err[k]));
            end
            check("req_ready_busy", 64'(req_ready[k]), 64'd0);
            if (hold_left[k] == 0) begin
               check("rsp_rdata", rsp_rdata[k], exp_q[0].rdata);
               check("rsp_err", 64'(rsp_err[k]), 64'(exp_q[0].err));
               void'(exp_q.pop_front());
               rsp_ready[k] = 1'b1;
               seen[k] = 1'b0;
            end else begin
               hold_left[k]--;
               rsp_ready[k] = 1'b0;
            end
         end
      end
   end

   task automatic issue(input int k, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask, input int hold);
      exp_t        e;
      logic [63:0] off;
      int          idx;
      int          waited = 0;
      req_valid[k] = 1'b1;
      req_wen[k]   = wen;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_wmask[k] = wmask;
      do begin
         @(negedge clk);
         waited++;
      end while (req_ready[k] !== 1'b1 && waited < 200);
      if (req_ready[k] !== 1'b1) begin
         check("req_accept_ready", 64'(req_ready[k]), 64'd1);
         req_valid[k] = 1'b0;
         return;
      end
      off       = addr - BASE;
      e.inst    = k;
      e.acc_cyc = cyc;
      e.hold    = hold;
      e.err     = (off >= SPAN);
      e.rdata   = 64'd0;
      if (!e.err) begin
         idx = int'(off >> 3);
         if (wen) begin
            for (int b = 0; b < 8; b++)
               if (wmask[b]) ref_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            e.rdata = ref_mem[k][idx];
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic probe_idle(input int k);
      int ones = 0;
      int zeros = 0;
      repeat (2) @(posedge clk);
      #1;
      repeat (48) begin
         @(negedge clk);
         if (req_ready[k] === 1'b1) ones++;
         else zeros++;
      end
`ifdef MR_RAND_STALL_EN
      check("idle_ready_seen_high", 64'(ones > 0), 64'd1);
      check("idle_ready_seen_low", 64'(zeros > 0), 64'd1);
`else
      check("idle_ready_low_count", 64'(zeros), 64'd0);
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: time limit expired with %0d pending", exp_q.size());
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          w;
      int          k;
      int          r;
      logic        wen;
      logic [63:0] addr;
      logic [7:0]  wmask;

      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_wen[i]   = 1'b0;
         req_addr[i]  = 64'd0;
         req_wdata[i] = 64'd0;
         req_wmask[i] = 8'd0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_req_ready", 64'(req_ready[i]), 64'd1);
         check("reset_rsp_valid", 64'(rsp_valid[i]), 64'd0);
         check("reset_rsp_rdata", rsp_rdata[i], 64'd0);
         check("reset_rsp_err", 64'(rsp_err[i]), 64'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] filling both RAMs");
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < DEPTH; j++)
            issue(i, 1'b1, BASE + 64'(j) * 64'd8, {$urandom, $urandom}, 8'hFF, 0);
         drain();
      end

      $display("[TB] write/read-back and partial mask");
      for (int i = 0; i < 2; i++) begin
         issue(i, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0);
         issue(i, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0);
         issue(i, 1'b1, BASE, 64'd0, 8'hFF, 0);
         issue(i, 1'b1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
         issue(i, 1'b0, BASE, 64'd0, 8'h00, 0);
         drain();
      end

      $display("[TB] held response on LATENCY=4");
      issue(1, 1'b0, BASE + 64'd8 * 64'd17, 64'd0, 8'h00, 3);
      issue(1, 1'b0, BASE + 64'd8 * 64'd200 + 64'd5, 64'd0, 8'h00, 3);
      drain();

      $display("[TB] out-of-range accesses");
      for (int i = 0; i < 2; i++) begin
         issue(i, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0);
         issue(i, 1'b0, BASE + SPAN, 64'd0, 8'h00, 1);
         issue(i, 1'b1, 64'h7FFF_FFF8, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0);
         issue(i, 1'b1, BASE + SPAN, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 0);
         issue(i, 1'b0, BASE + SPAN - 64'd8, 64'd0, 8'h00, 0);
         issue(i, 1'b0, BASE, 64'd0, 8'h00, 0);
         drain();
      end

      $display("[TB] reset during pending write");
      req_valid[1] = 1'b1;
      req_wen[1]   = 1'b1;
      req_addr[1]  = BASE + 64'd40;
      req_wdata[1] = 64'hDEAD_BEEF_0BAD_F00D;
      req_wmask[1] = 8'hFF;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (req_ready[1] !== 1'b1 && w < 200);
      check("rst_case_accept_ready", 64'(req_ready[1]), 64'd1);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_rsp_valid", 64'(rsp_valid[1]), 64'd0);
      check("rst_mid_req_ready", 64'(req_ready[1]), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(1, 1'b0, BASE + 64'd40, 64'd0, 8'h00, 0);
      drain();

      probe_idle(0);
      probe_idle(1);

      $display("[TB] random traffic");
      for (int blk = 0; blk < 50; blk++) begin
         k = int'($urandom_range(0, 1));
         for (int n = 0; n < 20; n++) begin
            wen = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 99));
            if (r < 6)
               addr = BASE - 64'd8 * 64'($urandom_range(1, 4));
            else if (r < 12)
               addr = BASE + SPAN + 64'd8 * 64'($urandom_range(0, 3));
            else
               addr = BASE + 64'd8 * 64'($urandom_range(0, DEPTH - 1));
            addr  = addr + 64'($urandom_range(0, 7));
            wmask = (r % 10 == 0) ? 8'h00 : 8'($urandom);
            issue(k, wen, addr, {$urandom, $urandom}, wmask, int'($urandom_range(0, 2)));
         end
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
